// File: rtl/pheap_op_scheduler_pkg.sv
// Shared heap types plus the scheduler's state encoding and occupancy limit.
package pheap_op_scheduler_pkg;

  localparam int LEVELS   = 16;
  localparam int CAPACITY = 2**LEVELS - 1;

  typedef logic [31:0] pValue;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    LEQ   = 2'd1,
    DEQ   = 2'd2,
    CLEAR = 2'd3
  } opcode_t;

  typedef struct packed {
    opcode_t levelOp;
    pValue   value;
  } opArray_t;

  typedef enum logic [1:0] {
    IDLE,
    DEQ_WAIT,
    CLEAR_WAIT
  } sched_state_t;

endpackage

// File: rtl/pheap_op_scheduler_rr_arbiter.sv
// Round-robin picker: first eligible client at or after ptr, wrapping around.
module pheap_op_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);

  int   cand;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/pheap_op_scheduler.sv
// Front-end scheduler for the pipelined priority heap: arbitrates client ops,
// tracks occupancy and serialises around DEQ results and CLEAR drains.
module pheap_op_scheduler #(
  parameter int NUM_REQ      = 2,
  parameter int CAPACITY     = pheap_op_scheduler_pkg::CAPACITY,
  parameter int CLEAR_CYCLES = pheap_op_scheduler_pkg::LEVELS
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [2*NUM_REQ-1:0]                    req_op,
  input  logic [32*NUM_REQ-1:0]                   req_value,
  output logic [NUM_REQ-1:0]                      req_ready,
  output logic [33:0]                             issue_op,
  input  logic                                    top_valid,
  input  logic [31:0]                             top_value,
  output logic                                    resp_valid,
  output logic [$clog2(NUM_REQ)-1:0]              resp_id,
  output logic [31:0]                             resp_value,
  output logic [pheap_op_scheduler_pkg::LEVELS-1:0] count,
  output logic                                    full,
  output logic                                    empty
);
  import pheap_op_scheduler_pkg::*;

  localparam int IW = $clog2(NUM_REQ);
  localparam int LW = LEVELS;
  localparam int CW = $clog2(CLEAR_CYCLES + 1);

  sched_state_t  state_reg, state_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [IW-1:0] id_reg, id_next;
  logic [CW-1:0] clr_cnt_reg, clr_cnt_next;
  logic [LW-1:0] count_reg, count_next;
  opArray_t      issue_reg, issue_next;

  logic [NUM_REQ-1:0] eligible, gnt;
  logic [IW-1:0]      gnt_idx;
  opcode_t            gnt_op;
  pValue              gnt_val;

  assign full  = (count_reg == LW'(CAPACITY));
  assign empty = (count_reg == '0);

  // Ineligible requests are masked out so the arbiter skips past them.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      opcode_t op_i;
      assign op_i = opcode_t'(req_op[2*gi +: 2]);
      assign eligible[gi] = req_valid[gi] && (state_reg == IDLE) &&
                            ((op_i != LEQ) || !full) &&
                            ((op_i != DEQ) || !empty);
    end
  endgenerate

  pheap_op_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_arbiter (
    .eligible (eligible),
    .ptr      (ptr_reg),
    .grant    (gnt),
    .idx      (gnt_idx)
  );

  assign req_ready = gnt;
  assign gnt_op    = opcode_t'(req_op[2*gnt_idx +: 2]);
  assign gnt_val   = req_value[32*gnt_idx +: 32];

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    id_next      = id_reg;
    clr_cnt_next = clr_cnt_reg;
    count_next   = count_reg;
    issue_next   = '{levelOp: FREE, value: '0};
    resp_valid   = 1'b0;
    resp_value   = '0;
    case (state_reg)
      IDLE: begin
        if (|gnt) begin
          ptr_next = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          case (gnt_op)
            LEQ: begin
              count_next = count_reg + 1'b1;
              issue_next = '{levelOp: LEQ, value: gnt_val};
            end
            DEQ: begin
              count_next = count_reg - 1'b1;
              issue_next = '{levelOp: DEQ, value: gnt_val};
              id_next    = gnt_idx;
              state_next = DEQ_WAIT;
            end
            CLEAR: begin
              count_next   = '0;
              issue_next   = '{levelOp: CLEAR, value: gnt_val};
              clr_cnt_next = CW'(CLEAR_CYCLES);
              state_next   = CLEAR_WAIT;
            end
            default: ; // FREE is acknowledged and dropped
          endcase
        end
      end
      DEQ_WAIT: begin
        if (top_valid) begin
          resp_valid = 1'b1;
          resp_value = top_value;
          state_next = IDLE;
        end
      end
      CLEAR_WAIT: begin
        clr_cnt_next = clr_cnt_reg - 1'b1;
        if (clr_cnt_reg <= CW'(1)) begin
          clr_cnt_next = '0;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      id_reg      <= '0;
      clr_cnt_reg <= '0;
      count_reg   <= '0;
      issue_reg   <= '{levelOp: FREE, value: '0};
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      id_reg      <= id_next;
      clr_cnt_reg <= clr_cnt_next;
      count_reg   <= count_next;
      issue_reg   <= issue_next;
    end
  end

  assign issue_op = issue_reg;
  assign resp_id  = id_reg;
  assign count    = count_reg;

endmodule

// File: tb/tb_pheap_op_scheduler.sv
// Bench for pheap_op_scheduler: directed vector table, hand sequences for CLEAR
// drain and async reset, then random traffic against a behavioural model.
module tb_pheap_op_scheduler;
  import pheap_op_scheduler_pkg::*;

  localparam int N   = 2;
  localparam int CAP = 6;
  localparam int CLR = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [3:0]  req_op;
  logic [63:0] req_value;
  logic [1:0]  req_ready;
  logic [33:0] issue_op;
  logic        top_valid;
  logic [31:0] top_value;
  logic        resp_valid;
  logic [0:0]  resp_id;
  logic [31:0] resp_value;
  logic [15:0] count;
  logic        full;
  logic        empty;

  always #5 clk = ~clk;

  pheap_op_scheduler #(
    .NUM_REQ      (N),
    .CAPACITY     (CAP),
    .CLEAR_CYCLES (CLR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_value  (req_value),
    .req_ready  (req_ready),
    .issue_op   (issue_op),
    .top_valid  (top_valid),
    .top_value  (top_value),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_value (resp_value),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: occupancy, mode (0 idle, 1 awaiting root, 2 draining),
  // remaining drain cycles, round-robin start and the expected issued op.
  int          m_count, m_mode, m_wait, m_ptr, m_id, g_pred;
  logic [1:0]  m_issue_op;
  logic [31:0] m_issue_val;

  function automatic int op_of(input int i);
    return int'(req_op[2*i +: 2]);
  endfunction

  function automatic int predict();
    if (m_mode != 0) return -1;
    for (int k = 0; k < N; k++) begin
      int i  = (m_ptr + k) % N;
      int op = op_of(i);
      if (req_valid[i] && !(op == 1 && m_count >= CAP) && !(op == 2 && m_count == 0))
        return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_count = 0; m_mode = 0; m_wait = 0; m_ptr = 0; m_id = 0;
    m_issue_op = 2'd0; m_issue_val = '0; g_pred = -1;
  endtask

  task automatic comb_check(input string tag);
    logic [1:0] exp_rdy;
    logic       exp_resp;
    g_pred   = predict();
    exp_rdy  = (g_pred < 0) ? 2'b00 : 2'(1 << g_pred);
    exp_resp = (m_mode == 1) && top_valid;
    check({tag, "_ready"}, 64'(req_ready), 64'(exp_rdy));
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'(exp_resp));
    if (exp_resp) begin
      check({tag, "_resp_id"}, 64'(resp_id), 64'(m_id));
      check({tag, "_resp_value"}, 64'(resp_value), 64'(top_value));
    end
  endtask

  task automatic step_model();
    int op;
    m_issue_op  = 2'd0;
    m_issue_val = '0;
    if (g_pred >= 0) begin
      op    = op_of(g_pred);
      m_ptr = (g_pred + 1) % N;
      case (op)
        1: begin m_count++; m_issue_op = 2'd1; m_issue_val = req_value[32*g_pred +: 32]; end
        2: begin m_count--; m_issue_op = 2'd2; m_issue_val = req_value[32*g_pred +: 32];
                 m_mode = 1; m_id = g_pred; end
        3: begin m_count = 0; m_issue_op = 2'd3; m_issue_val = req_value[32*g_pred +: 32];
                 m_mode = 2; m_wait = CLR; end
        default: ;
      endcase
      $display("t=%0t grant client %0d op %0d value %0h count %0d", $time, g_pred, op,
               req_value[32*g_pred +: 32], m_count);
    end else if (m_mode == 1 && top_valid) begin
      m_mode = 0;
    end else if (m_mode == 2) begin
      m_wait--;
      if (m_wait == 0) m_mode = 0;
    end
  endtask

  task automatic reg_check(input string tag);
    check({tag, "_issue_op"}, 64'(issue_op), 64'({m_issue_op, m_issue_val}));
    check({tag, "_count"}, 64'(count), 64'(m_count));
    check({tag, "_full"}, 64'(full), 64'(m_count == CAP));
    check({tag, "_empty"}, 64'(empty), 64'(m_count == 0));
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    comb_check(tag);
    @(posedge clk);
    step_model();
    #1;
    reg_check(tag);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] op0, input logic [1:0] op1,
                       input logic [31:0] val0, input logic [31:0] val1,
                       input logic tv, input logic [31:0] tval);
    req_valid = v;
    req_op    = {op1, op0};
    req_value = {val1, val0};
    top_valid = tv;
    top_value = tval;
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  op0;
    logic [1:0]  op1;
    logic [31:0] val0;
    logic [31:0] val1;
    logic        tv;
    logic [31:0] tval;
    logic [1:0]  exp_ready;
    logic        exp_resp;
    logic [1:0]  exp_op;
    int          exp_count;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // opcodes: 0 FREE, 1 LEQ, 2 DEQ, 3 CLEAR
    tbl[0]  = '{2'b01, 2'd1, 2'd0,  5,  0, 1'b0, 0, 2'b01, 1'b0, 2'd1, 1};
    tbl[1]  = '{2'b11, 2'd1, 2'd1, 10, 20, 1'b0, 0, 2'b10, 1'b0, 2'd1, 2};
    tbl[2]  = '{2'b11, 2'd1, 2'd1, 10, 20, 1'b0, 0, 2'b01, 1'b0, 2'd1, 3};
    tbl[3]  = '{2'b11, 2'd1, 2'd1, 10, 20, 1'b0, 0, 2'b10, 1'b0, 2'd1, 4};
    tbl[4]  = '{2'b11, 2'd1, 2'd1, 10, 20, 1'b0, 0, 2'b01, 1'b0, 2'd1, 5};
    tbl[5]  = '{2'b11, 2'd1, 2'd1, 10, 20, 1'b0, 0, 2'b10, 1'b0, 2'd1, 6};
    tbl[6]  = '{2'b11, 2'd1, 2'd1, 10, 20, 1'b0, 0, 2'b00, 1'b0, 2'd0, 6};
    tbl[7]  = '{2'b11, 2'd1, 2'd2,  7,  0, 1'b0, 0, 2'b10, 1'b0, 2'd2, 5};
    tbl[8]  = '{2'b11, 2'd1, 2'd2,  7,  0, 1'b0, 0, 2'b00, 1'b0, 2'd0, 5};
    tbl[9]  = '{2'b11, 2'd1, 2'd2,  7,  0, 1'b1, 3, 2'b00, 1'b1, 2'd0, 5};
    tbl[10] = '{2'b01, 2'd1, 2'd2,  7,  0, 1'b0, 0, 2'b01, 1'b0, 2'd1, 6};
    tbl[11] = '{2'b11, 2'd3, 2'd0, 44, 55, 1'b0, 0, 2'b10, 1'b0, 2'd0, 6};
    tbl[12] = '{2'b11, 2'd3, 2'd0, 44, 55, 1'b0, 0, 2'b01, 1'b0, 2'd3, 0};

    rst = 1'b1;
    drive(2'b00, 2'd0, 2'd0, 0, 0, 1'b0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_issue_op", 64'(issue_op), 64'd0);
    check("reset_ready", 64'(req_ready), 64'd0);
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    check("reset_resp_id", 64'(resp_id), 64'd0);
    check("reset_resp_value", 64'(resp_value), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    check("reset_empty", 64'(empty), 64'd1);
    check("reset_full", 64'(full), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].op0, tbl[i].op1, tbl[i].val0, tbl[i].val1, tbl[i].tv, tbl[i].tval);
      @(negedge clk);
      comb_check("tbl_model");
      check($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(tbl[i].exp_ready));
      check($sformatf("tbl%0d_resp", i), 64'(resp_valid), 64'(tbl[i].exp_resp));
      @(posedge clk);
      step_model();
      #1;
      reg_check("tbl_model");
      check($sformatf("tbl%0d_op", i), 64'(issue_op[33:32]), 64'(tbl[i].exp_op));
      check($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].exp_count));
    end

    // CLEAR drain: no grant for CLR cycles, then grants resume.
    drive(2'b01, 2'd1, 2'd0, 9, 0, 1'b0, 0);
    for (int k = 0; k < CLR; k++) begin
      @(negedge clk);
      check("clr_blocked", 64'(req_ready), 64'd0);
      comb_check("clr");
      @(posedge clk);
      step_model();
      #1;
      reg_check("clr");
    end
    @(negedge clk);
    check("clr_resume", 64'(req_ready), 64'd1);
    comb_check("clr");
    @(posedge clk);
    step_model();
    #1;
    reg_check("clr");

    // Drain to empty, then a DEQ beside an LEQ must yield to the LEQ.
    drive(2'b01, 2'd2, 2'd0, 0, 0, 1'b0, 0);
    cycle("deq");
    drive(2'b00, 2'd0, 2'd0, 0, 0, 1'b1, 32'h1234);
    cycle("deq_resp");
    drive(2'b11, 2'd2, 2'd1, 0, 9, 1'b0, 0);
    @(negedge clk);
    check("empty_deq_blocked", 64'(req_ready), 64'b10);
    comb_check("empty");
    @(posedge clk);
    step_model();
    #1;
    reg_check("empty");

    // Async reset while waiting for a DEQ result.
    drive(2'b01, 2'd2, 2'd0, 0, 0, 1'b0, 0);
    cycle("pre_rst_deq");
    drive(2'b00, 2'd0, 2'd0, 0, 0, 1'b0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_issue_op", 64'(issue_op), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_empty", 64'(empty), 64'd1);
    check("arst_full", 64'(full), 64'd0);
    check("arst_ready", 64'(req_ready), 64'd0);
    top_valid = 1'b1;
    top_value = 32'hdead;
    #1;
    check("arst_resp_valid", 64'(resp_valid), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cycle("post_rst");

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] ops[2];
      for (int c = 0; c < 2; c++) begin
        int r = $urandom_range(0, 19);
        ops[c] = (r < 10) ? 2'd1 : (r < 16) ? 2'd2 : (r < 18) ? 2'd0 : 2'd3;
      end
      drive(2'($urandom), ops[0], ops[1], $urandom, $urandom,
            ($urandom_range(0, 3) == 0), $urandom);
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pheap_op_scheduler.md
Name: pheap_op_scheduler

Overview:
- Front-end controller for the pipelined priority heap.
- Arbitrates enqueue (LEQ), dequeue (DEQ) and CLEAR requests from NUM_REQ clients using round-robin, and issues at most one operation per cycle into heap level 1 as an opArray_t.
- Tracks occupancy to block enqueue when full and dequeue when empty.
- Serialises around DEQ, whose root result must return before the next issue, and around CLEAR, which must drain through all levels.

Parameters:
- NUM_REQ, 2, number of requesting clients (2..8).
- CAPACITY, 2**LEVELS - 1, maximum heap occupancy (LEVELS comes from the shared package, default 16).
- CLEAR_CYCLES, LEVELS, number of idle cycles after a CLEAR issue.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-client request valid.
- req_op  in  NUM_REQ x 2  per-client opcode_t.
- req_value  in  NUM_REQ x 32  per-client pValue; used for LEQ only.
- req_ready  out  NUM_REQ  one-hot grant; the request is consumed on a cycle where valid && ready.
- issue_op  out  34  registered opArray_t to heap level 1; levelOp FREE means no operation.
- top_valid  in  1  the heap's root result for the outstanding DEQ is valid this cycle.
- top_value  in  32  root pValue returned by the heap.
- resp_valid  out  1  one-cycle pulse: dequeue result available.
- resp_id  out  $clog2(NUM_REQ)  client that issued the DEQ.
- resp_value  out  32  dequeued value.
- count  out  LEVELS  current occupancy.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.

Behaviour:
- Reset values: issue_op = {FREE, 0}; req_ready = 0; resp_valid = 0; resp_id = 0; resp_value = 0; count = 0; empty = 1; full = 0; state = IDLE; round-robin pointer = 0.
- Reset asserted mid-operation aborts any DEQ_WAIT or CLEAR_WAIT. A top_valid arriving after reset is ignored; resp_valid does not pulse.
- States and transitions:
  - IDLE: arbitration is enabled.
  - DEQ_WAIT: entered after a DEQ grant. Returns to IDLE on top_valid; in that cycle resp_valid=1, resp_value=top_value, resp_id=latched client id.
  - CLEAR_WAIT: entered after a CLEAR grant. A down-counter is loaded with CLEAR_CYCLES, and the state returns to IDLE when it reaches 0.
- Eligibility (IDLE only):
  - LEQ needs !full.
  - DEQ needs !empty.
  - CLEAR and FREE are always eligible.
  - Ineligible requests are skipped, not blocked; another client may be granted in the same cycle.
- Grant rule:
  - req_ready is combinational from state, pointer, req_valid, req_op, full and empty.
  - At most one bit is set.
  - Scan starts at the pointer; after a grant to client i the pointer becomes (i+1) mod NUM_REQ.
- Issue timing: a grant in cycle t produces issue_op in cycle t+1 with the granted op and value. In every other cycle issue_op.levelOp = FREE.
- FREE request: acknowledged and dropped. It is not issued, count is unchanged and it does not move to DEQ_WAIT; it still advances the pointer.
- Count update:
  - LEQ grant: count+1.
  - DEQ grant: count-1.
  - CLEAR grant: count = 0.
  - count, full and empty update in cycle t+1, together with issue_op.
- Back-to-back LEQ grants are allowed every cycle while not full.
- DEQ latency: issue to resp_valid is variable; there is no issue between them. top_valid outside DEQ_WAIT is ignored.
- Boundaries:
  - count == CAPACITY-1 with an LEQ grant: full asserts next cycle, and further LEQ is ineligible.
  - empty with DEQ pending: that request waits; it is not dropped.
  - req_valid deasserted without a handshake is permitted.

Decomposition:
- Add to pheapTypes:
  - sched_state_t enum {IDLE, DEQ_WAIT, CLEAR_WAIT}.
  - CAPACITY localparam.
  - Existing opcode_t, opArray_t and pValue are reused.
- Sub-module rr_arbiter (NUM_REQ): inputs eligible mask and pointer; outputs one-hot grant and index.
- The FSM, counters and output registers stay in the top module.

Test Plan:
- Reset then LEQ: client0 LEQ 5 -> req_ready[0] in cycle t; issue_op = {LEQ, 5} at t+1; count = 1; empty = 0.
- Round-robin: both clients hold LEQ (10, 20) for 4 cycles -> grants alternate 0, 1, 0, 1; issue values 10, 20, 10, 20; count = 4.
- DEQ serialisation: count = 2; client1 DEQ and client0 LEQ 7 concurrently -> DEQ granted, LEQ stalled. top_valid with top_value 3 after 5 cycles -> resp_valid = 1, resp_id = 1, resp_value = 3 that cycle. LEQ 7 granted the following cycle.
- Empty/full blocking: empty plus client0 DEQ -> req_ready stays 0; client1 LEQ 9 granted. Force count to CAPACITY -> LEQ never granted while DEQ is granted.
- CLEAR: count = 3 and client0 CLEAR -> issue_op = {CLEAR, x}; count = 0 next cycle; no grants for LEVELS (16) cycles; then grants resume.
- Async reset mid-DEQ_WAIT: assert rst between edges -> outputs at reset values immediately. A later top_valid produces no resp_valid.
